// File: rtl/fpa_pkg.sv
// fpa_pkg: field widths, exponent limit and aligner state encoding shared by the FP adder blocks.
package fpa_pkg;
    localparam int EXP_W  = 4;
    localparam int FRAC_W = 3;
    localparam int MANT_W = 5;
    localparam logic [EXP_W-1:0] EXP_MAX = 4'hF;
    typedef enum logic [1:0] {IDLE, CMP, SHIFT, HOLD} state_t;
endpackage

// File: rtl/fpa_unpack.sv
// fpa_unpack: splits a packed operand into sign, effective exponent and guarded mantissa.
// Ports: op (packed sign/exp/frac) -> sign, exp_eff (denormals read as 1), mant ({0, hidden, frac}).
module fpa_unpack
    import fpa_pkg::*;
(
    input  logic [7:0]        op,
    output logic              sign,
    output logic [EXP_W-1:0]  exp_eff,
    output logic [MANT_W-1:0] mant
);
    logic [EXP_W-1:0] fld;
    logic             hid;
    always_comb begin
        fld     = op[FRAC_W+EXP_W-1:FRAC_W];
        hid     = |fld;
        sign    = op[7];
        exp_eff = hid ? fld : EXP_W'(1);
        mant    = {1'b0, hid, op[FRAC_W-1:0]};
    end
endmodule

// File: rtl/fpa_operand_aligner.sv
// fpa_operand_aligner: orders an operand pair by exponent and right-aligns the smaller mantissa.
// Ports: clk, clr (async, active-high); in_valid/in_ready take a, b; out_valid/out_ready hand off
// sign_a/sign_b, exp_out, mant_a/mant_b, swapped and op_except held stable in HOLD.
module fpa_operand_aligner
    import fpa_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_a,
    output logic              sign_b,
    output logic [EXP_W-1:0]  exp_out,
    output logic [MANT_W-1:0] mant_a,
    output logic [MANT_W-1:0] mant_b,
    output logic              swapped,
    output logic              op_except
);
    state_t            state, nxt;
    logic [7:0]        ra, rb;
    logic              sa, sb, swp, exc;
    logic [EXP_W-1:0]  ea, eb, diff;
    logic [MANT_W-1:0] ma, mb;
    logic [2:0]        sh, cnt;

    fpa_unpack u_a (.op(ra), .sign(sa), .exp_eff(ea), .mant(ma));
    fpa_unpack u_b (.op(rb), .sign(sb), .exp_eff(eb), .mant(mb));

    // Ties keep input order; shifting past 5 places empties a 5-bit mantissa, so the count saturates.
    always_comb begin
        swp  = eb > ea;
        diff = swp ? eb - ea : ea - eb;
        sh   = diff > 4'd5 ? 3'd5 : diff[2:0];
        exc  = ea == EXP_MAX || eb == EXP_MAX;
    end

    always_ff @(posedge clk or posedge clr)
        if (clr) state <= IDLE;
        else     state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = in_valid ? CMP : IDLE;
            CMP:     nxt = (exc || sh == 3'd0) ? HOLD : SHIFT;
            SHIFT:   nxt = cnt == 3'd1 ? HOLD : SHIFT;
            HOLD:    nxt = out_ready ? IDLE : HOLD;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            ra        <= '0;
            rb        <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            exp_out   <= '0;
            mant_a    <= '0;
            mant_b    <= '0;
            cnt       <= '0;
            swapped   <= 1'b0;
            op_except <= 1'b0;
        end else
            case (state)
                IDLE:
                    if (in_valid) begin
                        ra <= a;
                        rb <= b;
                    end
                CMP: begin
                    swapped   <= swp;
                    op_except <= exc;
                    sign_a    <= swp ? sb : sa;
                    sign_b    <= swp ? sa : sb;
                    exp_out   <= swp ? eb : ea;
                    mant_a    <= swp ? mb : ma;
                    mant_b    <= swp ? ma : mb;
                    cnt       <= exc ? 3'd0 : sh;
                end
                SHIFT: begin
                    mant_b <= mant_b >> 1;
                    cnt    <= cnt - 3'd1;
                end
                default: ;
            endcase

    assign in_ready  = state == IDLE;
    assign out_valid = state == HOLD;
endmodule
